lcd_char_feeder: RTL and testbench



---
 rtl/lcd_char_feeder.sv | 176 +++++++++++++++++
 tb/tb_lcd_char_feeder.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_feeder.sv
// Character LCD feeder: FIFO-buffers ASCII bytes, tracks a 2-line cursor and issues
// one RS+byte transfer at a time over req/ack. Define LCD_FEEDER_CTRL_EN to interpret CR/LF.
module lcd_char_feeder #(
  parameter int FIFO_AW = 3,
  parameter int COLS    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clear_req,
  output logic               lcd_req,
  output logic               lcd_rs,
  output logic [7:0]         lcd_data,
  input  logic               lcd_ack,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(COLS + 1);
  localparam logic [CW-1:0]    LAST_COL = CW'(COLS - 1);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, CLR, ADDR, CHAR, GAP} state_t;

  state_t               state, state_n;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count, count_n;
  logic                 ready_q;
  logic                 push, pop;
  logic [7:0]           char_q;
  logic [CW-1:0]        col, col_n;
  logic                 row, row_n;
  logic                 clear_pending, clr_n;
  logic                 addr_pending, addr_n;

  assign push       = in_valid && ready_q;
  assign in_ready   = ready_q;
  assign fifo_count = count;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // in_ready is registered from the post-edge occupancy, so full is judged on the pre-edge count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_n;
      ready_q <= (count_n < FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    lcd_req  = 1'b0;
    lcd_rs   = 1'b0;
    lcd_data = 8'h00;
    col_n    = col;
    row_n    = row;
    clr_n    = clear_pending;
    addr_n   = addr_pending;
    case (state)
      IDLE: begin
        if (clear_pending) begin
          state_n = CLR;
        end else if (addr_pending) begin
          state_n = ADDR;
        end else if (count != '0) begin
          pop = 1'b1;
`ifdef LCD_FEEDER_CTRL_EN
          if (mem[rd_ptr] == 8'h0D) begin
            col_n  = '0;
            addr_n = 1'b1;
          end else if (mem[rd_ptr] == 8'h0A) begin
            col_n = '0;
            if (row) begin
              row_n = 1'b0;
              clr_n = 1'b1;
            end else begin
              row_n  = 1'b1;
              addr_n = 1'b1;
            end
          end else begin
            state_n = CHAR;
          end
`else
          state_n = CHAR;
`endif
        end
      end
      CLR: begin
        lcd_req  = 1'b1;
        lcd_data = 8'h01;
        if (lcd_ack) begin
          col_n   = '0;
          row_n   = 1'b0;
          clr_n   = 1'b0;
          addr_n  = 1'b0;
          state_n = GAP;
        end
      end
      ADDR: begin
        lcd_req  = 1'b1;
        lcd_data = row ? 8'hC0 : 8'h80;
        if (lcd_ack) begin
          addr_n  = 1'b0;
          state_n = GAP;
        end
      end
      CHAR: begin
        lcd_req  = 1'b1;
        lcd_rs   = 1'b1;
        lcd_data = char_q;
        if (lcd_ack) begin
          // A full line 0 moves to line 1; a full line 1 means the whole screen is used.
          if (col == LAST_COL) begin
            col_n = '0;
            if (!row) begin
              row_n  = 1'b1;
              addr_n = 1'b1;
            end else begin
              clr_n = 1'b1;
            end
          end else begin
            col_n = col + 1'b1;
          end
          state_n = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A clear request pulse is remembered even mid-transfer and wins over the FSM's own update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_q        <= 8'h00;
      col           <= '0;
      row           <= 1'b0;
      clear_pending <= 1'b1;
      addr_pending  <= 1'b0;
    end else begin
      if (pop) char_q <= mem[rd_ptr];
      col           <= col_n;
      row           <= row_n;
      clear_pending <= clr_n | clear_req;
      addr_pending  <= addr_n;
    end
  end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Randomized bench for lcd_char_feeder; expected transfers come from a linear cursor
// model (position 0..2*COLS-1) fed by every accepted byte.
module tb_lcd_char_feeder;

  localparam int FIFO_AW = 3;
  localparam int COLS    = 16;
  localparam int DEPTH   = 2 ** FIFO_AW;

  logic             clk;
  logic             rst_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             clear_req;
  logic             lcd_req;
  logic             lcd_rs;
  logic [7:0]       lcd_data;
  logic             lcd_ack;
  logic [FIFO_AW:0] fifo_count;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int ack_mode = 0;
  int pos     = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pend[$];
  int done_cyc[$];
  logic prev_req = 1'b0, prev_done = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  lcd_char_feeder #(.FIFO_AW(FIFO_AW), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear_req(clear_req), .lcd_req(lcd_req),
    .lcd_rs(lcd_rs), .lcd_data(lcd_data), .lcd_ack(lcd_ack),
    .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    lcd_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       lcd_ack = 1'b1;
        1:       lcd_ack = 1'($urandom_range(0, 1));
        default: lcd_ack = 1'b0;
      endcase
    end
  end

  // Reference: the cursor walks linearly over both lines; crossing into line 1 costs
  // an address command, wrapping back to position 0 costs a clear.
  function automatic void model_accept(input logic [7:0] b);
`ifdef LCD_FEEDER_CTRL_EN
    if (b == 8'h0D) begin
      pos = (pos / COLS) * COLS;
      exp_q.push_back({1'b0, (pos >= COLS) ? 8'hC0 : 8'h80});
      return;
    end
    if (b == 8'h0A) begin
      if (pos < COLS) begin
        pos = COLS;
        exp_q.push_back({1'b0, 8'hC0});
      end else begin
        pos = 0;
        exp_q.push_back({1'b0, 8'h01});
      end
      return;
    end
`endif
    exp_q.push_back({1'b1, b});
    pos = (pos + 1) % (2 * COLS);
    if (pos == COLS) exp_q.push_back({1'b0, 8'hC0});
    else if (pos == 0) exp_q.push_back({1'b0, 8'h01});
  endfunction

  function automatic void model_clear();
    pos = 0;
    exp_q.push_back({1'b0, 8'h01});
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        vectors++;
        if (lcd_req !== 1'b0) begin
          errors++;
          $display("[TB] FAIL req_gap: lcd_req=%b after completion, required 0", lcd_req);
        end
      end
      if (prev_req && !prev_done && lcd_req) begin
        vectors++;
        if ({lcd_rs, lcd_data} !== {prev_rs, prev_data}) begin
          errors++;
          $display("[TB] FAIL hold_stable: rs/data=%b/%h, required %b/%h", lcd_rs, lcd_data, prev_rs, prev_data);
        end
      end
      if (lcd_req && lcd_ack) begin
        vectors++;
        done_cyc.push_back(cyc + 1);
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL transfer: got unexpected rs/data=%b/%h, required none", lcd_rs, lcd_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({lcd_rs, lcd_data} !== e) begin
            errors++;
            $display("[TB] FAIL transfer: got rs/data=%b/%h, required %b/%h", lcd_rs, lcd_data, e[8], e[7:0]);
          end
        end
      end
      prev_req  = lcd_req;
      prev_done = lcd_req && lcd_ack;
      prev_rs   = lcd_rs;
      prev_data = lcd_data;
    end
  end

  task automatic send_pending(input int gap_max);
    int guard;
    while (pend.size() > 0) begin
      in_data  = pend[0];
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 400) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (!in_ready) begin
        vectors++;
        errors++;
        $display("[TB] FAIL push_stall: in_ready=%b after %0d cycles, required 1", in_ready, guard);
        in_valid = 1'b0;
        pend.delete();
        return;
      end
      model_accept(pend.pop_front());
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_count != '0 || lcd_req) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n >= limit) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d transfers outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (lcd_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle: lcd_req=%b, required 0", name, lcd_req);
    end
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear_req = 1'b0; ack_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({lcd_req, lcd_rs, lcd_data, fifo_count, in_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: req/rs/data/count/ready=%b/%b/%h/%0d/%b, required all 0",
               lcd_req, lcd_rs, lcd_data, fifo_count, in_ready);
    end
    model_clear();
    rst_n = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: in_ready=%b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_release: in_ready=%b, required 1", in_ready);
    end
    wait_drain("reset", 50);
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_idle: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    done_cyc.delete();
    t0 = cyc + 1;
    pend.push_back(8'h41);
    pend.push_back(8'h42);
    send_pending(0);
    wait_drain("b2b", 50);
    vectors++;
    if (done_cyc.size() != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: %0d transfers, required 2", done_cyc.size());
    end else begin
      vectors++;
      if (done_cyc[0] - t0 != 2) begin
        errors++;
        $display("[TB] FAIL b2b_latency: %0d cycles push to done, required 2", done_cyc[0] - t0);
      end
      vectors++;
      if (done_cyc[1] - done_cyc[0] != 3) begin
        errors++;
        $display("[TB] FAIL b2b_throughput: %0d cycles between transfers, required 3", done_cyc[1] - done_cyc[0]);
      end
    end
  endtask

  task automatic test_line_wrap();
    pulse_clear();
    model_clear();
    for (int i = 0; i < 17; i++) pend.push_back(8'(8'h30 + i));
    send_pending(0);
    wait_drain("wrap", 300);
  endtask

  task automatic test_screen_wrap();
    pulse_clear();
    model_clear();
    for (int i = 0; i < 33; i++) pend.push_back(8'($urandom_range(32, 126)));
    send_pending(1);
    wait_drain("screen", 600);
  endtask

  task automatic test_fifo_full();
    int accepted = 0;
    ack_mode = 2;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(8'h60 + i);
      if (!in_ready) break;
      model_accept(in_data);
      accepted++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (accepted != DEPTH + 1) begin
      errors++;
      $display("[TB] FAIL full_accepted: %0d bytes, required %0d", accepted, DEPTH + 1);
    end
    vectors++;
    if (fifo_count !== (FIFO_AW + 1)'(DEPTH)) begin
      errors++;
      $display("[TB] FAIL full_count: fifo_count=%0d, required %0d", fifo_count, DEPTH);
    end
    in_data = 8'h7F;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (fifo_count !== (FIFO_AW + 1)'(DEPTH) || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_hold: count/ready=%0d/%b, required %0d/0", fifo_count, in_ready, DEPTH);
    end
    ack_mode = 0;
    wait_drain("full", 300);
  endtask

  task automatic test_clear_mid();
    int n = 0;
    pulse_clear();
    model_clear();
    wait_drain("clr_pre", 50);
    ack_mode = 2;
    pend.push_back(8'h51);
    send_pending(0);
    while (!(lcd_req && lcd_rs) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (!(lcd_req && lcd_rs)) begin
      errors++;
      $display("[TB] FAIL clear_mid_req: req/rs=%b/%b, required 1/1", lcd_req, lcd_rs);
    end
    pulse_clear();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    ack_mode = 0;
    for (int i = 0; i < COLS; i++) pend.push_back(8'(8'h61 + i));
    send_pending(0);
    wait_drain("clear_mid", 300);
  endtask

  task automatic test_ctrl_codes();
`ifdef LCD_FEEDER_CTRL_EN
    pulse_clear();
    model_clear();
    pend.push_back(8'h58);
    pend.push_back(8'h0A);
    pend.push_back(8'h59);
    pend.push_back(8'h0D);
    pend.push_back(8'h5A);
    pend.push_back(8'h0A);
    pend.push_back(8'h5B);
    send_pending(0);
    wait_drain("ctrl", 200);
`else
    pend.push_back(8'h0D);
    pend.push_back(8'h0A);
    send_pending(0);
    wait_drain("ctrl_plain", 100);
`endif
  endtask

  task automatic test_random();
    int r;
    ack_mode = 1;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      pend.push_back(8'h0A);
      else if (r == 1) pend.push_back(8'h0D);
      else             pend.push_back(8'($urandom_range(32, 126)));
    end
    send_pending(2);
    wait_drain("random", 6000);
    ack_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ack_mode = 2;
    pend.push_back(8'h4D);
    pend.push_back(8'h4E);
    pend.push_back(8'h4F);
    send_pending(0);
    while (!lcd_req && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (lcd_req !== 1'b0 || fifo_count !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: req/count/ready=%b/%0d/%b, required 0/0/0", lcd_req, fifo_count, in_ready);
    end
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #1;
    ack_mode = 0;
    rst_n = 1'b1;
    wait_drain("reset_mid", 50);
    pend.push_back(8'h21);
    send_pending(0);
    wait_drain("post_reset", 50);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_screen_wrap();
    test_fifo_full();
    test_clear_mid();
    test_ctrl_codes();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
